// File: rtl/axis_jtag_multi_v2.sv
// AXI-Stream command engine that shifts TMS/TDI vectors into one of C_NUM_CHAN JTAG chains
// and returns captured TDO bits. Define AXIS_JTAG_LOOPBACK_EN to make channel 0xFF an internal loopback.
module axis_jtag_multi_v2 #(
    parameter int C_VEC_WIDTH       = 32,
    parameter int C_NUM_CHAN        = 2,
    parameter int C_TCK_CLOCK_RATIO = 4
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [2*C_VEC_WIDTH-1:0] s_axis_tdata,
    input  logic [15:0]              s_axis_tuser,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [C_VEC_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [C_NUM_CHAN-1:0]    jtag_tck,
    output logic [C_NUM_CHAN-1:0]    jtag_tms,
    output logic [C_NUM_CHAN-1:0]    jtag_tdi,
    input  logic [C_NUM_CHAN-1:0]    jtag_tdo,
    output logic                     busy,
    output logic                     err_chan
);

    localparam int HALF = C_TCK_CLOCK_RATIO / 2;
    localparam int LW   = (C_VEC_WIDTH > 1) ? $clog2(C_VEC_WIDTH) : 1;
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, RESP} state_t;

    state_t                 state;
    logic [C_VEC_WIDTH-1:0] tdi_r, tms_r, capture, cap_next, mdata_q;
    logic [LW-1:0]          len_r, bit_cnt, bit_nxt;
    logic [PW-1:0]          phase;
    logic [C_NUM_CHAN-1:0]  sel_mask, tck_q, tms_q, tdi_q, cmd_mask;
    logic                   loop_r, tready_q, mvalid_q, mlast_q, err_q;
    logic [7:0]             cmd_chan, cmd_len;
    logic                   cmd_legal, cmd_loop, phase_last, cap_bit;

    assign cmd_chan   = s_axis_tuser[15:8];
    assign cmd_len    = (s_axis_tuser[7:0] > 8'(C_VEC_WIDTH-1)) ? 8'(C_VEC_WIDTH-1) : s_axis_tuser[7:0];
    assign cmd_legal  = cmd_chan < 8'(C_NUM_CHAN);
`ifdef AXIS_JTAG_LOOPBACK_EN
    assign cmd_loop   = cmd_chan == 8'hFF;
`else
    assign cmd_loop   = 1'b0;
`endif
    assign cmd_mask   = cmd_legal ? (C_NUM_CHAN'(1) << cmd_chan) : '0;
    assign bit_nxt    = bit_cnt + LW'(1);
    assign phase_last = phase == PW'(HALF-1);
    // Loopback reflects the TDI bit; otherwise only the selected chain's TDO contributes.
    assign cap_bit    = loop_r ? tdi_r[bit_cnt] : |(jtag_tdo & sel_mask);

    always_comb begin
        cap_next = capture;
        if (state == SHIFT_HI && phase == '0)
            cap_next[bit_cnt] = cap_bit;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state    <= IDLE;
            tdi_r    <= '0;
            tms_r    <= '0;
            capture  <= '0;
            mdata_q  <= '0;
            len_r    <= '0;
            bit_cnt  <= '0;
            phase    <= '0;
            sel_mask <= '0;
            tck_q    <= '0;
            tms_q    <= '0;
            tdi_q    <= '0;
            loop_r   <= 1'b0;
            tready_q <= 1'b0;
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    tready_q <= 1'b1;
                    if (s_axis_tvalid && tready_q) begin
                        tready_q <= 1'b0;
                        tdi_r    <= s_axis_tdata[C_VEC_WIDTH-1:0];
                        tms_r    <= s_axis_tdata[2*C_VEC_WIDTH-1:C_VEC_WIDTH];
                        len_r    <= cmd_len[LW-1:0];
                        mlast_q  <= s_axis_tlast;
                        bit_cnt  <= '0;
                        phase    <= '0;
                        capture  <= '0;
                        sel_mask <= cmd_mask;
                        loop_r   <= cmd_loop;
                        if (cmd_legal || cmd_loop) begin
                            state <= SHIFT_LO;
                            // Bit 0 goes out with the accept so TCK-low starts the very next cycle.
                            if (cmd_legal) begin
                                tms_q <= s_axis_tdata[C_VEC_WIDTH] ? cmd_mask : '0;
                                tdi_q <= s_axis_tdata[0] ? cmd_mask : '0;
                            end
                        end else begin
                            err_q    <= 1'b1;
                            state    <= RESP;
                            mvalid_q <= 1'b1;
                            mdata_q  <= '0;
                        end
                    end
                end
                SHIFT_LO: begin
                    phase <= phase + PW'(1);
                    if (phase_last) begin
                        phase <= '0;
                        state <= SHIFT_HI;
                        tck_q <= sel_mask;
                    end
                end
                SHIFT_HI: begin
                    capture <= cap_next;
                    phase   <= phase + PW'(1);
                    if (phase_last) begin
                        phase <= '0;
                        tck_q <= '0;
                        if (bit_cnt == len_r) begin
                            state    <= RESP;
                            mvalid_q <= 1'b1;
                            mdata_q  <= cap_next;
                        end else begin
                            bit_cnt <= bit_nxt;
                            state   <= SHIFT_LO;
                            if (!loop_r) begin
                                tms_q <= tms_r[bit_nxt] ? sel_mask : '0;
                                tdi_q <= tdi_r[bit_nxt] ? sel_mask : '0;
                            end
                        end
                    end
                end
                RESP: begin
                    if (m_axis_tready) begin
                        mvalid_q <= 1'b0;
                        tready_q <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = mdata_q;
    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tlast  = mlast_q;
    assign jtag_tck      = tck_q;
    assign jtag_tms      = tms_q;
    assign jtag_tdi      = tdi_q;
    assign busy          = state != IDLE;
    assign err_chan      = err_q;

endmodule

// File: tb/tb_axis_jtag_multi_v2.sv
// Directed bench for axis_jtag_multi_v2: chain 1 TDO is driven by the bench, chain 0 TDO loops back TDI.
module tb_axis_jtag_multi_v2;

    localparam int VW = 32;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [2*VW-1:0] s_tdata = '0;
    logic [15:0]     s_tuser = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic            s_tlast = 1'b0;
    logic [VW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic            m_tlast;
    logic [NC-1:0]   jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
    logic            busy, err_chan;
    logic            tdo1 = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int rise0 = 0;
    int rise1 = 0;
    logic [31:0] tdi_seq = '0;
    logic [31:0] tms_seq = '0;

    always #5 clk = ~clk;

    assign jtag_tdo = {tdo1, jtag_tdi[0]};

    axis_jtag_multi_v2 #(.C_VEC_WIDTH(VW), .C_NUM_CHAN(NC), .C_TCK_CLOCK_RATIO(4)) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
        .busy(busy), .err_chan(err_chan)
    );

    always @(posedge jtag_tck[0]) rise0 <= rise0 + 1;

    always @(posedge jtag_tck[1]) begin
        rise1   <= rise1 + 1;
        tdi_seq <= {tdi_seq[30:0], jtag_tdi[1]};
        tms_seq <= {tms_seq[30:0], jtag_tms[1]};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one command and waits (bounded) for the response; lat counts edges after the accept edge.
    task automatic send(input logic [2*VW-1:0] data, input logic [15:0] user, input logic last,
                        output int lat, output logic err_at1, output int err_cnt);
        int w = 0;
        while (!s_tready && w < 50) begin
            step();
            w++;
        end
        check("ready_before_cmd", s_tready, 1'b1);
        s_tdata  = data;
        s_tuser  = user;
        s_tlast  = last;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        s_tuser  = 16'hFF00;
        err_at1  = err_chan;
        err_cnt  = 0;
        lat      = 1;
        while (!m_tvalid && lat < 400) begin
            step();
            lat++;
            if (err_chan) err_cnt++;
        end
    endtask

    task automatic ack();
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        check("idle_after_ack", {busy, s_tready, m_tvalid}, 3'b010);
    endtask

    initial begin
        int   lat, ec, r0, r1;
        logic e1;

        // 1: reset
        step(5);
        check("reset_outputs", {s_tready, m_tvalid, m_tlast, busy, err_chan, jtag_tck, jtag_tms, jtag_tdi, m_tdata},
              '0);
        rstn = 1'b1;
        step();
        check("ready_after_reset", {s_tready, busy}, 2'b10);

        // 2: chain 1, eight bits, TDO tied high
        tdo1 = 1'b1;
        r0 = rise0; r1 = rise1;
        send({32'h0000_0080, 32'h0000_00A5}, 16'h0107, 1'b0, lat, e1, ec);
        check("s2_latency", lat, 33);
        check("s2_tdata", m_tdata, 32'hFF);
        check("s2_tlast", m_tlast, 1'b0);
        check("s2_tck1_rises", rise1 - r1, 8);
        check("s2_tck0_rises", rise0 - r0, 0);
        check("s2_tdi_seq", tdi_seq[7:0], 8'hA5);
        check("s2_tms_seq", tms_seq[7:0], 8'h01);
        check("s2_no_err", {e1, ec[7:0]}, 9'h0);
        ack();
        check("s2_pins_hold", {jtag_tck, jtag_tms, jtag_tdi}, 6'b00_10_10);

        // 3: chain 0 loops TDI to TDO through the bench, full 32 bits
        r0 = rise0; r1 = rise1;
        send({32'h0, 32'hDEAD_BEEF}, 16'h001F, 1'b1, lat, e1, ec);
        check("s3_latency", lat, 129);
        check("s3_tdata", m_tdata, 32'hDEAD_BEEF);
        check("s3_tlast", m_tlast, 1'b1);
        check("s3_rises", {rise0 - r0, rise1 - r1}, {32'd32, 32'd0});
        ack();
        check("s3_pins_hold", {jtag_tck, jtag_tms, jtag_tdi}, 6'b00_00_01);

        // 4: back-pressure on the response
        send({32'h0000_0080, 32'h0000_00A5}, 16'h0107, 1'b0, lat, e1, ec);
        check("s4_latency", lat, 33);
        r0 = rise0; r1 = rise1;
        step(10);
        check("s4_held", {m_tvalid, s_tready, busy, m_tdata}, {3'b101, 32'hFF});
        check("s4_no_tck", {rise0 - r0, rise1 - r1}, 64'h0);
        ack();

        // 5: illegal channel
        r0 = rise0; r1 = rise1;
        send({32'h0, 32'h5}, 16'h0503, 1'b1, lat, e1, ec);
        check("s5_latency", lat, 1);
        check("s5_err_pulse", e1, 1'b1);
        check("s5_resp", {m_tlast, m_tdata}, {1'b1, 32'h0});
        step();
        check("s5_err_one_cycle", {err_chan, m_tvalid}, 2'b01);
        check("s5_no_tck", {rise0 - r0, rise1 - r1}, 64'h0);
        ack();
`ifdef AXIS_JTAG_LOOPBACK_EN
        r0 = rise0; r1 = rise1;
        send({32'h0, 32'h5}, 16'hFF03, 1'b0, lat, e1, ec);
        check("s5_loop_latency", lat, 17);
        check("s5_loop_tdata", m_tdata, 32'h5);
        check("s5_loop_no_err", {e1, ec[7:0]}, 9'h0);
        check("s5_loop_no_tck", {rise0 - r0, rise1 - r1}, 64'h0);
        ack();
`else
        send({32'h0, 32'h5}, 16'hFF03, 1'b0, lat, e1, ec);
        check("s5_ff_illegal", {lat[7:0], e1, m_tdata}, {8'd1, 1'b1, 32'h0});
        ack();
`endif

        // Bit count above the vector width saturates to 32 bits
        r1 = rise1;
        send({32'h0, 32'h0}, 16'h01FF, 1'b0, lat, e1, ec);
        check("sat_latency", lat, 129);
        check("sat_tdata", m_tdata, 32'hFFFF_FFFF);
        check("sat_rises", rise1 - r1, 32);
        ack();

        // 6: reset in the middle of bit 3
        s_tdata  = {32'h0000_0080, 32'h0000_00A5};
        s_tuser  = 16'h0107;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        step(13);
        check("s6_busy_mid", busy, 1'b1);
        rstn = 1'b0;
        step();
        check("s6_abort", {jtag_tck, jtag_tms, jtag_tdi, m_tvalid, busy, s_tready}, '0);
        step(2);
        rstn = 1'b1;
        step();
        check("s6_no_resp", {m_tvalid, s_tready}, 2'b01);
        r0 = rise0; r1 = rise1;
        send({32'h0000_0080, 32'h0000_00A5}, 16'h0107, 1'b0, lat, e1, ec);
        check("s6_repeat", {lat[7:0], m_tdata, tdi_seq[7:0], tms_seq[7:0]}, {8'd33, 32'hFF, 8'hA5, 8'h01});
        check("s6_repeat_rises", {rise0 - r0, rise1 - r1}, {32'd0, 32'd8});
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
